// File: rtl/map_fetch_pkg.sv
// Shared types for the map_fetch stage: FSM state encoding, region select
// values and the request record used for both pending latches and the memory port.
package map_fetch_pkg;

    localparam int FETCH_ADDR_W = 25;

    localparam logic REGION_PRG = 1'b0;
    localparam logic REGION_CHR = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        PPU_BUSY = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                    we;
        logic [FETCH_ADDR_W-1:0] addr;
        logic [7:0]              wdata;
    } fetch_req_t;

    localparam fetch_req_t REQ_RESET = '0;

endpackage

// File: rtl/map_fetch_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin plus a third history flop
// that turns level changes into single-cycle rise/fall pulses.
module edge_sync
    import map_fetch_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Resetting all stages to the pin's idle level keeps the first cycles
    // after reset free of phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/map_fetch.sv
// Turns mapper PRG/CHR strobes into single-outstanding requests on the shared
// cartridge memory port (PPU first) and holds the last read byte per region.
module map_fetch
    import map_fetch_pkg::*;
#(
    parameter int ADDR_BITS     = 24,
    parameter int MEM_ADDR_BITS = ADDR_BITS + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m2,
    input  logic [ADDR_BITS-1:0]     prg_addr,
    input  logic                     prg_oe,
    input  logic                     prg_we,
    input  logic [7:0]               cpu_data_in,
    input  logic                     ppu_rd_n,
    input  logic                     ppu_wr_n,
    input  logic [ADDR_BITS-1:0]     chr_addr,
    input  logic                     chr_oe,
    input  logic                     chr_we,
    input  logic [7:0]               ppu_data_in,
    output logic [7:0]               prg_rdata,
    output logic [7:0]               chr_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic                     mem_ack,
    input  logic [7:0]               mem_rdata,
    output logic                     overrun
);

    // state    | meaning
    // IDLE     | no request outstanding; next edge issues PPU before CPU
    // CPU_BUSY | PRG request on the memory port, waiting for mem_ack
    // PPU_BUSY | CHR request on the memory port, waiting for mem_ack

    logic m2_rise, m2_fall;
    logic rd_rise, rd_fall;
    logic wr_rise, wr_fall;
    logic unused_edges;

    edge_sync #(.RST_VAL(1'b0)) u_m2_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (m2),
        .rise (m2_rise),
        .fall (m2_fall)
    );

    edge_sync #(.RST_VAL(1'b1)) u_rd_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ppu_rd_n),
        .rise (rd_rise),
        .fall (rd_fall)
    );

    edge_sync #(.RST_VAL(1'b1)) u_wr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ppu_wr_n),
        .rise (wr_rise),
        .fall (wr_fall)
    );

    assign unused_edges = rd_rise ^ wr_fall;

    logic cpu_rd_ev, cpu_wr_ev, cpu_ev;
    logic ppu_rd_ev, ppu_wr_ev, ppu_ev;

    assign cpu_rd_ev = m2_rise & prg_oe;
    assign cpu_wr_ev = m2_fall & prg_we;
    assign cpu_ev    = cpu_rd_ev | cpu_wr_ev;
    assign ppu_rd_ev = rd_fall & chr_oe;
    assign ppu_wr_ev = wr_rise & chr_we;
    assign ppu_ev    = ppu_rd_ev | ppu_wr_ev;

    fetch_state_t state_q, state_d;
    logic         cpu_pend_q, cpu_pend_d;
    logic         ppu_pend_q, ppu_pend_d;
    fetch_req_t   cpu_lat_q, cpu_lat_d;
    fetch_req_t   ppu_lat_q, ppu_lat_d;
    fetch_req_t   mem_q, mem_d;
    logic         mem_req_q, mem_req_d;
    logic [7:0]   prg_rdata_q, prg_rdata_d;
    logic [7:0]   chr_rdata_q, chr_rdata_d;
    logic         overrun_q, overrun_d;
    logic         cpu_issue, ppu_issue;

    always_comb begin
        state_d     = state_q;
        cpu_pend_d  = cpu_pend_q;
        ppu_pend_d  = ppu_pend_q;
        cpu_lat_d   = cpu_lat_q;
        ppu_lat_d   = ppu_lat_q;
        mem_d       = mem_q;
        mem_req_d   = mem_req_q;
        prg_rdata_d = prg_rdata_q;
        chr_rdata_d = chr_rdata_q;
        overrun_d   = overrun_q;
        cpu_issue   = 1'b0;
        ppu_issue   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ppu_pend_q) begin
                    state_d   = PPU_BUSY;
                    mem_d     = ppu_lat_q;
                    mem_req_d = 1'b1;
                    ppu_issue = 1'b1;
                end else if (cpu_pend_q) begin
                    state_d   = CPU_BUSY;
                    mem_d     = cpu_lat_q;
                    mem_req_d = 1'b1;
                    cpu_issue = 1'b1;
                end
            end
            CPU_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_q.we) begin
                        prg_rdata_d = mem_rdata;
                    end
                end
            end
            PPU_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_q.we) begin
                        chr_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (cpu_issue) begin
            cpu_pend_d = 1'b0;
        end
        if (ppu_issue) begin
            ppu_pend_d = 1'b0;
        end

        // A fresh event beats the issue-clear; only an unissued entry counts as lost.
        if (cpu_ev) begin
            if (cpu_pend_q && !cpu_issue) begin
                overrun_d = 1'b1;
            end
            cpu_pend_d      = 1'b1;
            cpu_lat_d.we    = cpu_wr_ev;
            cpu_lat_d.addr  = FETCH_ADDR_W'({REGION_PRG, prg_addr});
            cpu_lat_d.wdata = cpu_data_in;
        end

        if (ppu_ev) begin
            if (ppu_pend_q && !ppu_issue) begin
                overrun_d = 1'b1;
            end
            ppu_pend_d      = 1'b1;
            ppu_lat_d.we    = ppu_wr_ev;
            ppu_lat_d.addr  = FETCH_ADDR_W'({REGION_CHR, chr_addr});
            ppu_lat_d.wdata = ppu_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_pend_q  <= 1'b0;
            ppu_pend_q  <= 1'b0;
            cpu_lat_q   <= REQ_RESET;
            ppu_lat_q   <= REQ_RESET;
            mem_q       <= REQ_RESET;
            mem_req_q   <= 1'b0;
            prg_rdata_q <= 8'h00;
            chr_rdata_q <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_pend_q  <= cpu_pend_d;
            ppu_pend_q  <= ppu_pend_d;
            cpu_lat_q   <= cpu_lat_d;
            ppu_lat_q   <= ppu_lat_d;
            mem_q       <= mem_d;
            mem_req_q   <= mem_req_d;
            prg_rdata_q <= prg_rdata_d;
            chr_rdata_q <= chr_rdata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_q.we;
    assign mem_addr  = MEM_ADDR_BITS'(mem_q.addr);
    assign mem_wdata = mem_q.wdata;
    assign prg_rdata = prg_rdata_q;
    assign chr_rdata = chr_rdata_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_map_fetch.sv
// Directed bench for map_fetch: stimulus pushes hand-computed expected requests,
// a monitor pops them as the DUT raises mem_req, and a responder plays memory.
module tb_map_fetch;

    logic        clk;
    logic        rst_n;
    logic        m2;
    logic [23:0] prg_addr;
    logic        prg_oe;
    logic        prg_we;
    logic [7:0]  cpu_data_in;
    logic        ppu_rd_n;
    logic        ppu_wr_n;
    logic [23:0] chr_addr;
    logic        chr_oe;
    logic        chr_we;
    logic [7:0]  ppu_data_in;
    logic [7:0]  prg_rdata;
    logic [7:0]  chr_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        overrun;

    map_fetch #(.ADDR_BITS(24), .MEM_ADDR_BITS(25)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m2         (m2),
        .prg_addr   (prg_addr),
        .prg_oe     (prg_oe),
        .prg_we     (prg_we),
        .cpu_data_in(cpu_data_in),
        .ppu_rd_n   (ppu_rd_n),
        .ppu_wr_n   (ppu_wr_n),
        .chr_addr   (chr_addr),
        .chr_oe     (chr_oe),
        .chr_we     (chr_we),
        .ppu_data_in(ppu_data_in),
        .prg_rdata  (prg_rdata),
        .chr_rdata  (chr_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  prg;
        logic [7:0]  chr;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_model [logic [24:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_delay = 4;
    bit          ack_hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic [24:0] addr, input logic [7:0] wdata,
                            input logic [7:0] prg, input logic [7:0] chr, input int len);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.prg = prg; e.chr = chr; e.len = len;
        exp_q.push_back(e);
    endtask

    // Memory side: ack after ack_delay cycles (longer while ack_hold), abandon on reset.
    initial begin : responder
        bit abort;
        int guard;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req && rst_n) begin
                abort = 1'b0;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    if (!mem_req) begin
                        abort = 1'b1;
                        break;
                    end
                end
                guard = 0;
                while (ack_hold && !abort && guard < 500) begin
                    @(negedge clk);
                    if (!mem_req) abort = 1'b1;
                    guard++;
                end
                if (!abort) begin
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        int          len;
        bit          unstable;
        logic [24:0] addr0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_addr), 32'h0);
                    chk("unexpected_req_flag", 32'(mem_req), 32'h0);
                    for (int i = 0; i < 600 && mem_req; i++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", 32'(mem_we), 32'(e.we));
                    chk("req_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
                    addr0    = mem_addr;
                    unstable = 1'b0;
                    len      = 1;
                    @(negedge clk);
                    while (mem_req && len < 600) begin
                        if (mem_addr !== addr0 || mem_we !== e.we) unstable = 1'b1;
                        len++;
                        @(negedge clk);
                    end
                    chk("req_stable", 32'(unstable), 32'h0);
                    chk("req_dropped", 32'(mem_req), 32'h0);
                    if (e.len != 0) chk("req_len", 32'(len), 32'(e.len));
                    chk("prg_rdata", 32'(prg_rdata), 32'(e.prg));
                    chk("chr_rdata", 32'(chr_rdata), 32'(e.chr));
                end
            end
        end
    end

    task automatic settle();
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_req) break;
        end
        if (i == 400) chk("settle_timeout", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [23:0] a);
        @(negedge clk);
        prg_addr = a; prg_oe = 1'b1; prg_we = 1'b0; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0; prg_oe = 1'b0;
    endtask

    task automatic cpu_write(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        prg_oe = 1'b0; prg_we = 1'b0; m2 = 1'b1;
        repeat (5) @(negedge clk);
        prg_addr = a; cpu_data_in = d; prg_we = 1'b1; m2 = 1'b0;
        repeat (6) @(negedge clk);
        prg_we = 1'b0;
    endtask

    task automatic ppu_read(input logic [23:0] a);
        @(negedge clk);
        chr_addr = a; chr_oe = 1'b1; ppu_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        ppu_rd_n = 1'b1; chr_oe = 1'b0;
    endtask

    task automatic ppu_write(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        chr_addr = a; ppu_data_in = d; chr_we = 1'b1; ppu_wr_n = 1'b0;
        repeat (5) @(negedge clk);
        ppu_wr_n = 1'b1;
        repeat (6) @(negedge clk);
        chr_we = 1'b0;
    endtask

    initial begin : stimulus
        rst_n = 1'b0; m2 = 1'b0; prg_addr = '0; prg_oe = 1'b0; prg_we = 1'b0;
        cpu_data_in = 8'h00; ppu_rd_n = 1'b1; ppu_wr_n = 1'b1; chr_addr = '0;
        chr_oe = 1'b0; chr_we = 1'b0; ppu_data_in = 8'h00;

        mem_model[25'h0001234] = 8'hA5;
        mem_model[25'h1000100] = 8'h5A;
        mem_model[25'h0000300] = 8'hC3;
        mem_model[25'h0000400] = 8'h11;
        mem_model[25'h1000010] = 8'h99;
        mem_model[25'h1000020] = 8'h22;
        mem_model[25'h0000500] = 8'hEE;
        mem_model[25'h0000600] = 8'h42;

        repeat (4) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_prg_rdata", 32'(prg_rdata), 32'h0);
        chk("rst_chr_rdata", 32'(chr_rdata), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_req_after_rst", 32'(mem_req), 32'h0);

        // CPU read, exact request length with a 4-cycle ack
        push_exp(1'b0, 25'h0001234, 8'h00, 8'hA5, 8'h00, 5);
        cpu_read(24'h001234);
        settle();

        // CPU write leaves prg_rdata alone
        push_exp(1'b1, 25'h0000200, 8'h3C, 8'hA5, 8'h00, 0);
        cpu_write(24'h000200, 8'h3C);
        settle();

        // Simultaneous PPU and CPU reads: PPU goes first
        push_exp(1'b0, 25'h1000100, 8'h00, 8'hA5, 8'h5A, 0);
        push_exp(1'b0, 25'h0000300, 8'h00, 8'hC3, 8'h5A, 0);
        @(negedge clk);
        chr_addr = 24'h000100; chr_oe = 1'b1; prg_addr = 24'h000300; prg_oe = 1'b1;
        m2 = 1'b1; ppu_rd_n = 1'b0;
        repeat (6) @(negedge clk);
        m2 = 1'b0; prg_oe = 1'b0; ppu_rd_n = 1'b1; chr_oe = 1'b0;
        settle();
        chk("overrun_clear", 32'(overrun), 32'h0);

        // Overrun: two PPU reads while CPU transaction stalls
        ack_hold = 1'b1;
        push_exp(1'b0, 25'h0000400, 8'h00, 8'h11, 8'h5A, 0);
        push_exp(1'b0, 25'h1000020, 8'h00, 8'h11, 8'h22, 0);
        cpu_read(24'h000400);
        chk("stall_req", 32'(mem_req), 32'h1);
        ppu_read(24'h000010);
        ppu_read(24'h000020);
        chk("overrun_set", 32'(overrun), 32'h1);
        ack_hold = 1'b0;
        settle();
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // CHR write then read back through the memory
        push_exp(1'b1, 25'h1000040, 8'h77, 8'h11, 8'h22, 0);
        ppu_write(24'h000040, 8'h77);
        settle();
        push_exp(1'b0, 25'h1000040, 8'h00, 8'h11, 8'h77, 0);
        ppu_read(24'h000040);
        settle();

        // Reset in the middle of a stalled transaction
        ack_hold = 1'b1;
        push_exp(1'b0, 25'h0000500, 8'h00, 8'h00, 8'h00, 0);
        cpu_read(24'h000500);
        chk("pre_reset_req", 32'(mem_req), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_req", 32'(mem_req), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        ack_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("quiet_after_reset", 32'(mem_req), 32'h0);
        chk("reset_prg_rdata", 32'(prg_rdata), 32'h0);

        // Fresh pin edge after reset is served normally
        push_exp(1'b0, 25'h0000600, 8'h00, 8'h42, 8'h00, 5);
        cpu_read(24'h000600);
        settle();

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
